// File: rtl/regfile_multi_seq.sv
// LDM/STM sequencer: walks a 16-bit register list lowest-first, one memory
// transfer per register, then writes back the updated base register.
// Ports: clk, reset (sync, active-high); start/is_load/up/pre/wback,
// base_reg, base_val, reglist (request); busy, done (status);
// ra/rd (register read), we/wa/wd (register write), pc_we/pc_wdata
// (PC load); mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready.
// Option: define LSM_PC_LOAD_EN to let an LDM of r15 load the PC.
module regfile_multi_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_load,
  input  logic             up,
  input  logic             pre,
  input  logic             wback,
  input  logic [3:0]       base_reg,
  input  logic [WIDTH-1:0] base_val,
  input  logic [15:0]      reglist,
  output logic             busy,
  output logic             done,
  output logic [3:0]       ra,
  input  logic [WIDTH-1:0] rd,
  output logic             we,
  output logic [3:0]       wa,
  output logic [WIDTH-1:0] wd,
  output logic             pc_we,
  output logic [WIDTH-1:0] pc_wdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    FINISH
  } state_t;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(4);

  state_t           state, state_nx;
  logic [15:0]      list_q, list_nx;
  logic [WIDTH-1:0] addr_q, addr_nx;
  logic [WIDTH-1:0] base_q;
  logic [4:0]       cnt_q, cnt_in;
  logic             load_q, up_q, wb_q;
  logic [3:0]       breg_q;
  logic [3:0]       cur;
  logic             last;
  logic [WIDTH-1:0] span, wb_span, start_addr;

  always_comb begin
    cnt_in = '0;
    for (int i = 0; i < 16; i++)
      cnt_in = cnt_in + 5'(reglist[i]);
  end

  assign span    = WIDTH'({cnt_in, 2'b00});
  assign wb_span = WIDTH'({cnt_q, 2'b00});

  // Block always occupies [lowest, highest] ascending, whatever the direction.
  always_comb begin
    unique case ({up, pre})
      2'b10:   start_addr = base_val;
      2'b11:   start_addr = base_val + STEP;
      2'b00:   start_addr = base_val - span + STEP;
      default: start_addr = base_val - span;
    endcase
  end

  always_comb begin
    cur = '0;
    for (int i = 15; i >= 0; i--)
      if (list_q[i]) cur = 4'(i);
  end

  assign last = (list_q & (list_q - 16'd1)) == 16'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      list_q <= '0;
      addr_q <= '0;
      base_q <= '0;
      cnt_q  <= '0;
      load_q <= 1'b0;
      up_q   <= 1'b0;
      wb_q   <= 1'b0;
      breg_q <= '0;
    end else begin
      state  <= state_nx;
      list_q <= list_nx;
      addr_q <= addr_nx;
      if (state == IDLE && start) begin
        base_q <= base_val;
        cnt_q  <= cnt_in;
        load_q <= is_load;
        up_q   <= up;
        breg_q <= base_reg;
        // Empty list, or a load that overwrites the base, skips writeback.
        wb_q   <= wback && (|reglist)
                  && !(is_load && reglist[base_reg]);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    list_nx   = list_q;
    addr_nx   = addr_q;
    busy      = 1'b0;
    done      = 1'b0;
    ra        = '0;
    we        = 1'b0;
    wa        = '0;
    wd        = '0;
    pc_we     = 1'b0;
    pc_wdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (|reglist) begin
            state_nx = XFER;
            list_nx  = reglist;
            addr_nx  = start_addr;
          end else begin
            state_nx = FINISH;
          end
        end
      end
      XFER: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_we   = !load_q;
        mem_addr = addr_q;
        if (!load_q) begin
          ra        = cur;
          mem_wdata = rd;
        end
        if (mem_ready) begin
          list_nx = list_q & ~(16'd1 << cur);
          addr_nx = addr_q + STEP;
          if (last) state_nx = FINISH;
          if (load_q) begin
            if (cur != 4'd15) begin
              we = 1'b1;
              wa = cur;
              wd = mem_rdata;
            end else begin
`ifdef LSM_PC_LOAD_EN
              pc_we    = 1'b1;
              pc_wdata = mem_rdata;
`else
              pc_we    = 1'b0;
              pc_wdata = '0;
`endif
            end
          end
        end
      end
      FINISH: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
        if (wb_q) begin
          we = 1'b1;
          wa = breg_q;
          wd = up_q ? base_q + wb_span : base_q - wb_span;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Nothing leaves the block while reset is held: no writes, no requests.
    if (reset) begin
      busy      = 1'b0;
      done      = 1'b0;
      ra        = '0;
      we        = 1'b0;
      wa        = '0;
      wd        = '0;
      pc_we     = 1'b0;
      pc_wdata  = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

endmodule
